// File: rtl/tlp_tx_arbiter.sv
// Packet-level arbiter for the shared 64-bit FPGA->CPU TLP transmit stream.
// Whole TLPs are granted SOP..EOP; req0 can optionally preempt the round-robin group between packets.
module tlp_tx_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter bit HIPRI_REQ0  = 1'b1,
    parameter int STALL_LIMIT = 255
) (
    input  logic                  clk_in,
    input  logic                  rstn_in,
    input  logic [NUM_REQ*64-1:0] req_data_in,
    input  logic [NUM_REQ-1:0]    req_valid_in,
    input  logic [NUM_REQ-1:0]    req_sop_in,
    input  logic [NUM_REQ-1:0]    req_eop_in,
    output logic [NUM_REQ-1:0]    req_ready_out,
    output logic [63:0]           tx_data_out,
    output logic                  tx_valid_out,
    output logic                  tx_sop_out,
    output logic                  tx_eop_out,
    input  logic                  tx_ready_in,
    output logic [NUM_REQ-1:0]    grant_out,
    output logic                  stall_out,
    output logic                  err_out,
    input  logic                  err_clr_in
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(STALL_LIMIT + 1);
    localparam logic [IW-1:0] RR_RST = HIPRI_REQ0 ? IW'(1) : '0;

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e             state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_inc;
    logic               stall_q, stall_d, err_q, err_d;
    logic               mid_q, mid_d;

    logic [63:0]        dat [NUM_REQ];
    logic [NUM_REQ-1:0] cand;
    logic [IW-1:0]      win, jj;
    logic               found, own_vld, own_sop, own_eop, acc, err_set, stall_set;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign dat[g] = req_data_in[64*g +: 64];
    end

    // Winner search: req0 preempts when prioritised, else scan upward from rr_q.
    always_comb begin
        cand  = req_valid_in & req_sop_in;
        win   = rr_q;
        found = 1'b0;
        jj    = '0;
        if (HIPRI_REQ0 && cand[0]) begin
            win   = '0;
            found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                jj = IW'((int'(rr_q) + k) % NUM_REQ);
                if (!found && cand[jj] && !(HIPRI_REQ0 && jj == '0)) begin
                    win   = jj;
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        own_vld = req_valid_in[owner_q];
        own_sop = req_sop_in[owner_q];
        own_eop = req_eop_in[owner_q];
        acc     = (state_q == LOCKED) && own_vld && tx_ready_in;
        cnt_inc = (cnt_q == CW'(STALL_LIMIT)) ? cnt_q : cnt_q + 1'b1;

        state_d       = state_q;
        owner_d       = owner_q;
        grant_d       = grant_q;
        rr_d          = rr_q;
        cnt_d         = '0;
        mid_d         = mid_q;
        err_set       = 1'b0;
        stall_set     = 1'b0;
        tx_data_out   = dat[owner_q];
        tx_valid_out  = 1'b0;
        tx_sop_out    = 1'b0;
        tx_eop_out    = 1'b0;
        req_ready_out = '0;

        case (state_q)
            IDLE: begin
                mid_d = 1'b0;
                // A mid-packet beat with no owner is never accepted, only flagged.
                if (|(req_valid_in & ~req_sop_in)) err_set = 1'b1;
                if (found) begin
                    state_d = LOCKED;
                    owner_d = win;
                    grant_d = NUM_REQ'(1) << win;
                end
            end
            LOCKED: begin
                tx_valid_out  = own_vld;
                tx_sop_out    = own_sop;
                tx_eop_out    = own_eop;
                req_ready_out = tx_ready_in ? grant_q : '0;
                if (own_vld && own_sop && mid_q) err_set = 1'b1;
                if (acc) mid_d = 1'b1;
                if (!own_vld) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(STALL_LIMIT)) stall_set = 1'b1;
                end
                if (acc && own_eop) begin
                    state_d = IDLE;
                    grant_d = '0;
                    mid_d   = 1'b0;
                    if (HIPRI_REQ0 && owner_q == '0)
                        rr_d = rr_q;
                    else if (owner_q == IW'(NUM_REQ - 1))
                        rr_d = RR_RST;
                    else
                        rr_d = owner_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        err_d   = err_clr_in ? 1'b0 : (err_q | err_set);
        stall_d = err_clr_in ? 1'b0 : (stall_q | stall_set);
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q <= IDLE;
            owner_q <= '0;
            grant_q <= '0;
            rr_q    <= RR_RST;
            cnt_q   <= '0;
            stall_q <= 1'b0;
            err_q   <= 1'b0;
            mid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            err_q   <= err_d;
            mid_q   <= mid_d;
        end
    end

    assign grant_out = grant_q;
    assign stall_out = stall_q;
    assign err_out   = err_q;

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Scoreboard bench for tlp_tx_arbiter: per-requester beat sources, expected TX beats queued in grant order,
// and a monitor that checks every accepted TX beat against the queue.
module tb_tlp_tx_arbiter;
    localparam int N = 3;

    typedef struct { logic bub; logic [63:0] d; logic sop; logic eop; } beat_t;
    typedef struct { int src; logic [63:0] d; logic sop; logic eop; } exp_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N*64-1:0] req_data_in;
    logic [N-1:0]    req_valid_in, req_sop_in, req_eop_in, req_ready_out;
    logic [63:0]     tx_data_out;
    logic            tx_valid_out, tx_sop_out, tx_eop_out, tx_ready_in;
    logic [N-1:0]    grant_out;
    logic            stall_out, err_out, err_clr, tog_en;

    beat_t srcq [N][$];
    exp_t  expq [$];
    int    acc_cyc [$];
    int    cyc = 0;
    int    pass_cnt = 0;
    int    tot_cnt = 0;

    always #5 clk = ~clk;

    tlp_tx_arbiter #(.NUM_REQ(N), .HIPRI_REQ0(1'b1), .STALL_LIMIT(4)) dut (
        .clk_in(clk), .rstn_in(rstn),
        .req_data_in(req_data_in), .req_valid_in(req_valid_in),
        .req_sop_in(req_sop_in), .req_eop_in(req_eop_in), .req_ready_out(req_ready_out),
        .tx_data_out(tx_data_out), .tx_valid_out(tx_valid_out), .tx_sop_out(tx_sop_out),
        .tx_eop_out(tx_eop_out), .tx_ready_in(tx_ready_in), .grant_out(grant_out),
        .stall_out(stall_out), .err_out(err_out), .err_clr_in(err_clr)
    );

    function automatic logic [63:0] mkd(input int r, input int p, input int b);
        return {8'(r), 24'(p), 32'(b)};
    endfunction

    // n-beat packet from requester r; bub idle cycles inserted before beat bat; xsop adds a stray SOP.
    task automatic add_pkt(input int r, input int p, input int n, input int bat, input int bub,
                           input int xsop, input bit to_src, input bit to_exp);
        beat_t b;
        exp_t  e;
        for (int i = 0; i < n; i++) begin
            if (to_src && i == bat) begin
                for (int k = 0; k < bub; k++) begin
                    b.bub = 1'b1; b.d = '0; b.sop = 1'b0; b.eop = 1'b0;
                    srcq[r].push_back(b);
                end
            end
            b.bub = 1'b0; b.d = mkd(r, p, i); b.sop = (i == 0) || (i == xsop); b.eop = (i == n - 1);
            if (to_src) srcq[r].push_back(b);
            e.src = r; e.d = b.d; e.sop = b.sop; e.eop = b.eop;
            if (to_exp) expq.push_back(e);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        tot_cnt++;
        if (act === want) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    endtask

    task automatic wait_drain(input int maxc, input string nm);
        int c = 0;
        while ((expq.size() != 0 || srcq[0].size() != 0 || srcq[1].size() != 0 ||
                srcq[2].size() != 0) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        tot_cnt++;
        if (c < maxc) pass_cnt++;
        else $display("FAIL %s: drain timeout, %0d expected beats left", nm, expq.size());
        repeat (2) @(negedge clk);
    endtask

    // Requester driver: acceptance is sampled at negedge, inputs change 1ns after posedge.
    initial begin
        logic [N-1:0] acc;
        logic [N-1:0] pres_bub;
        beat_t        b;
        req_valid_in = '0; req_sop_in = '0; req_eop_in = '0; req_data_in = '0; pres_bub = '0;
        forever begin
            @(negedge clk);
            acc = req_valid_in & req_ready_out;
            @(posedge clk);
            #1;
            for (int r = 0; r < N; r++) begin
                if ((acc[r] || pres_bub[r]) && srcq[r].size() > 0) void'(srcq[r].pop_front());
                pres_bub[r] = 1'b0;
                if (srcq[r].size() > 0) begin
                    b = srcq[r][0];
                    req_valid_in[r] = !b.bub;
                    req_sop_in[r]   = b.sop;
                    req_eop_in[r]   = b.eop;
                    req_data_in[64*r +: 64] = b.d;
                    pres_bub[r] = b.bub;
                end else begin
                    req_valid_in[r] = 1'b0;
                    req_sop_in[r]   = 1'b0;
                    req_eop_in[r]   = 1'b0;
                end
            end
        end
    end

    initial begin
        tx_ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready_in = tog_en ? ~tx_ready_in : 1'b1;
        end
    end

    // Monitor: every accepted TX beat must match the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rstn && tx_valid_out && tx_ready_in) begin
                acc_cyc.push_back(cyc);
                tot_cnt++;
                if (expq.size() == 0) begin
                    $display("FAIL beat: unexpected beat d=%h grant=%b", tx_data_out, grant_out);
                end else begin
                    e = expq.pop_front();
                    if (tx_data_out === e.d && tx_sop_out === e.sop && tx_eop_out === e.eop &&
                        grant_out === N'(1 << e.src))
                        pass_cnt++;
                    else
                        $display("FAIL beat: got d=%h sop=%b eop=%b grant=%b, expected d=%h sop=%b eop=%b src=%0d",
                                 tx_data_out, tx_sop_out, tx_eop_out, grant_out, e.d, e.sop, e.eop, e.src);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c, idle_n;
        beat_t b;
        rstn = 1'b0; err_clr = 1'b0; tog_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_grant", grant_out, 0);
        chk("rst_tx_valid", tx_valid_out, 0);
        chk("rst_ready", req_ready_out, 0);
        chk("rst_err", err_out, 0);
        chk("rst_stall", stall_out, 0);
        @(posedge clk); #1 rstn = 1'b1;

        // Reset in the middle of a req1 packet
        add_pkt(1, 1, 6, 0, 0, -1, 1'b1, 1'b1);
        c = 0;
        while (acc_cyc.size() < 3 && c < 50) begin @(negedge clk); c++; end
        chk("t1_three_beats", acc_cyc.size(), 3);
        @(posedge clk); #2;
        rstn = 1'b0;
        #1;
        chk("t1_rst_grant", grant_out, 0);
        chk("t1_rst_tx_valid", tx_valid_out, 0);
        chk("t1_rst_ready", req_ready_out, 0);
        srcq[1].delete();
        expq.delete();
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rstn = 1'b1;
        add_pkt(2, 2, 2, 0, 0, -1, 1'b1, 1'b1);
        wait_drain(50, "t1_after_rst");
        chk("t1_err", err_out, 0);

        // Round-robin between req1 and req2 streaming 4-beat packets
        acc_cyc.delete();
        add_pkt(1, 10, 4, 0, 0, -1, 1'b1, 1'b0);
        add_pkt(1, 12, 4, 0, 0, -1, 1'b1, 1'b0);
        add_pkt(2, 11, 4, 0, 0, -1, 1'b1, 1'b0);
        add_pkt(2, 13, 4, 0, 0, -1, 1'b1, 1'b0);
        add_pkt(1, 10, 4, 0, 0, -1, 1'b0, 1'b1);
        add_pkt(2, 11, 4, 0, 0, -1, 1'b0, 1'b1);
        add_pkt(1, 12, 4, 0, 0, -1, 1'b0, 1'b1);
        add_pkt(2, 13, 4, 0, 0, -1, 1'b0, 1'b1);
        wait_drain(200, "t2_rr");
        chk("t2_beats", acc_cyc.size(), 16);
        if (acc_cyc.size() == 16) begin
            chk("t2_back_to_back", acc_cyc[3] - acc_cyc[0], 3);
            chk("t2_one_bubble", acc_cyc[4] - acc_cyc[3], 2);
            chk("t2_total_span", acc_cyc[15] - acc_cyc[0], 18);
        end

        // req0 completion arrives mid DMA packet; it must win over req2 afterwards
        add_pkt(1, 20, 34, 0, 0, -1, 1'b1, 1'b1);
        add_pkt(0, 21, 3, 0, 5, -1, 1'b1, 1'b0);
        add_pkt(2, 22, 2, 0, 0, -1, 1'b1, 1'b0);
        add_pkt(0, 21, 3, 0, 0, -1, 1'b0, 1'b1);
        add_pkt(2, 22, 2, 0, 0, -1, 1'b0, 1'b1);
        wait_drain(300, "t3_prio");
        chk("t3_err", err_out, 0);

        // Backpressure: tx_ready toggles every cycle
        acc_cyc.delete();
        tog_en = 1'b1;
        add_pkt(1, 30, 6, 0, 0, -1, 1'b1, 1'b1);
        c = 0;
        while ((expq.size() != 0 || srcq[1].size() != 0) && c < 60) begin
            @(negedge clk);
            c++;
            if (grant_out[1]) chk("t4_ready_mirror", req_ready_out, {1'b0, tx_ready_in, 1'b0});
        end
        tog_en = 1'b0;
        wait_drain(10, "t4_bp");
        chk("t4_beats", acc_cyc.size(), 6);
        if (acc_cyc.size() == 6) chk("t4_span", acc_cyc[5] - acc_cyc[0], 10);
        chk("t4_stall", stall_out, 0);

        // Protocol error: req2 valid without SOP while idle
        b.bub = 1'b0; b.d = mkd(2, 40, 0); b.sop = 1'b0; b.eop = 1'b1;
        srcq[2].push_back(b);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_no_forward", {grant_out, tx_valid_out}, 0);
        end
        chk("t5_err_nosop", err_out, 1);
        srcq[2].delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        chk("t5_err_clr", err_out, 0);

        // Protocol error: SOP on the second beat of a packet, still forwarded
        add_pkt(1, 41, 3, 0, 0, 1, 1'b1, 1'b1);
        wait_drain(50, "t5_midsop");
        chk("t5_err_midsop", err_out, 1);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        chk("t5_err_clr2", err_out, 0);

        // Stall: owner idles 5 cycles mid-packet, limit is 4
        add_pkt(1, 50, 4, 2, 5, -1, 1'b1, 1'b1);
        idle_n = 0;
        c = 0;
        while ((expq.size() != 0 || srcq[1].size() != 0) && c < 60) begin
            @(negedge clk);
            c++;
            if (grant_out[1] && !req_valid_in[1]) begin
                idle_n++;
                chk("t6_stall_timing", stall_out, (idle_n >= 5) ? 1 : 0);
            end
        end
        wait_drain(10, "t6_stall");
        chk("t6_idle_cycles", idle_n, 5);
        chk("t6_stall_sticky", stall_out, 1);
        chk("t6_grant_released", grant_out, 0);
        chk("t6_err", err_out, 0);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        chk("t6_stall_clr", stall_out, 0);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
